local_bias_ctrl: RTL and testbench

Power-up sequencer and supervisor that sits directly upstream of local_bias and drives its pdb and atb_ena inputs. Behaviour:
- Debounces the analog supply rails.
- Releases power-down, then waits for the bias currents to settle.
- Checks the returned 25 uA / 500 uA bias currents against tolerance.
- Flags bias_ready to downstream DAC logic, or latches a fault.
- It is an RNM block: real-valued supply and current-sense inputs, sampled on the clock.

---
 rtl/local_bias_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_local_bias_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_bias_ctrl.sv
// Power-up sequencer and supervisor for local_bias: debounces the analog rails, releases pdb,
// waits for the bias currents to settle, verifies them, then raises bias_ready or latches a fault.
module local_bias_ctrl #(
   parameter int  SUP_DEBOUNCE   = 8,
   parameter int  SETTLE_CYCLES  = 64,
   parameter int  VERIFY_TIMEOUT = 32,
   parameter real I_TOL          = 0.10,
   parameter real VDDANA_1P8_REF = 1.8,
   parameter real VDDANA_0P8_REF = 0.8,
   parameter real VSSANA_TOL     = 0.05
) (
   input  logic       clk,
   input  logic       rstb,
   input  logic       en,
   input  real        vddana_1p8,
   input  real        vddana_0p8,
   input  real        vssana,
   input  real        iclkdist_sense,
   input  real        icurrentsterring_sense,
   input  logic [0:1] atb_req,
   input  logic       fault_clr,
   output logic       pdb,
   output logic [0:1] atb_ena,
   output logic       bias_ready,
   output logic       fault,
   output logic [1:0] fault_code,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_OFF      = 3'd0,
      S_SUP_WAIT = 3'd1,
      S_SETTLE   = 3'd2,
      S_VERIFY   = 3'd3,
      S_READY    = 3'd4,
      S_FAULT    = 3'd5
   } state_t;

   localparam logic [1:0] FC_NONE   = 2'b00;
   localparam logic [1:0] FC_SUPPLY = 2'b01;
   localparam logic [1:0] FC_CURR   = 2'b10;
   localparam logic [1:0] FC_SETTLE = 2'b11;

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_SAT    = '1;
   localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(SUP_DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] VER_LAST   = CNT_W'(VERIFY_TIMEOUT - 1);

   localparam real V18_LO = VDDANA_1P8_REF * 0.95;
   localparam real V18_HI = VDDANA_1P8_REF * 1.05;
   localparam real V08_LO = VDDANA_0P8_REF * 0.95;
   localparam real V08_HI = VDDANA_0P8_REF * 1.05;
   localparam real I25_LO  = 25.0e-6 * (1.0 - I_TOL);
   localparam real I25_HI  = 25.0e-6 * (1.0 + I_TOL);
   localparam real I500_LO = 500.0e-6 * (1.0 - I_TOL);
   localparam real I500_HI = 500.0e-6 * (1.0 + I_TOL);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             glitch_q, glitch_d;
   logic [1:0]       fault_code_q, fault_code_d;
   logic             pdb_q, pdb_d;
   logic             bias_ready_q, bias_ready_d;
   logic             fault_q, fault_d;
   logic [0:1]       atb_ena_q, atb_ena_d;
   logic             sup_ok, i_ok;

   // Every comparison against NaN (and hence a high-Z wreal sample) is false, so such samples
   // fall out of window without a dedicated test.
   always_comb begin : window_checks
      sup_ok = (vddana_1p8 >= V18_LO) && (vddana_1p8 <= V18_HI) &&
               (vddana_0p8 >= V08_LO) && (vddana_0p8 <= V08_HI) &&
               (vssana >= -VSSANA_TOL) && (vssana <= VSSANA_TOL);
      i_ok   = (iclkdist_sense >= I25_LO) && (iclkdist_sense <= I25_HI) &&
               (icurrentsterring_sense >= I500_LO) && (icurrentsterring_sense <= I500_HI);
   end

   always_comb begin : next_state
      state_d      = state_q;
      fault_code_d = fault_code_q;
      glitch_d     = glitch_q;
      cnt_d        = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
      unique case (state_q)
         S_OFF: begin
            cnt_d = '0;
            if (en) state_d = S_SUP_WAIT;
         end
         S_SUP_WAIT: begin
            if (!en)                        state_d = S_OFF;
            else if (!sup_ok)               cnt_d   = '0;
            else if (cnt_q == DEB_LAST)     state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (!en) state_d = S_OFF;
            else if (!sup_ok) begin
               state_d      = S_FAULT;
               fault_code_d = FC_SETTLE;
            end else if (cnt_q == SET_LAST) state_d = S_VERIFY;
         end
         S_VERIFY: begin
            if (!en) state_d = S_OFF;
            else if (!sup_ok) begin
               state_d      = S_FAULT;
               fault_code_d = FC_SUPPLY;
            end else if (i_ok) state_d = S_READY;
            else if (cnt_q == VER_LAST) begin
               state_d      = S_FAULT;
               fault_code_d = FC_CURR;
            end
         end
         S_READY: begin
            if (!en) state_d = S_OFF;
            else if (!sup_ok) begin
               state_d      = S_FAULT;
               fault_code_d = FC_SUPPLY;
            end else if (!i_ok && glitch_q) begin
               state_d      = S_FAULT;
               fault_code_d = FC_CURR;
            end else glitch_d = !i_ok;
         end
         S_FAULT: begin
            if (fault_clr && !en) begin
               state_d      = S_OFF;
               fault_code_d = FC_NONE;
            end
         end
         default: state_d = S_OFF;
      endcase
      // Counter and glitch memory restart on every state change.
      if (state_d != state_q) begin
         cnt_d    = '0;
         glitch_d = 1'b0;
      end
   end

   always_comb begin : output_decode
      pdb_d        = 1'b0;
      bias_ready_d = 1'b0;
      fault_d      = 1'b0;
      atb_ena_d    = 2'b00;
      unique case (state_d)
         S_SETTLE, S_VERIFY: pdb_d = 1'b1;
         S_READY: begin
            pdb_d        = 1'b1;
            bias_ready_d = 1'b1;
            atb_ena_d    = atb_req;
         end
         S_FAULT: fault_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin : state_reg
      if (!rstb) begin
         state_q      <= S_OFF;
         cnt_q        <= '0;
         glitch_q     <= 1'b0;
         fault_code_q <= FC_NONE;
         pdb_q        <= 1'b0;
         bias_ready_q <= 1'b0;
         fault_q      <= 1'b0;
         atb_ena_q    <= 2'b00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         glitch_q     <= glitch_d;
         fault_code_q <= fault_code_d;
         pdb_q        <= pdb_d;
         bias_ready_q <= bias_ready_d;
         fault_q      <= fault_d;
         atb_ena_q    <= atb_ena_d;
      end
   end

   assign pdb        = pdb_q;
   assign bias_ready = bias_ready_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
   assign atb_ena    = atb_ena_q;
   assign state      = state_q;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Bench for local_bias_ctrl: randomized rails/currents, expected timing derived from
// run-length rules over the sampled inputs.
module tb_local_bias_ctrl;

   localparam int  SUP_DEBOUNCE   = 8;
   localparam int  SETTLE_CYCLES  = 64;
   localparam int  VERIFY_TIMEOUT = 32;
   localparam real I_TOL          = 0.10;
   localparam int  PDB_EDGE       = 1 + SUP_DEBOUNCE;
   localparam int  FIRST_CHECK    = PDB_EDGE + SETTLE_CYCLES + 1;

   logic       clk = 1'b0;
   logic       rstb = 1'b0;
   logic       en = 1'b0;
   logic       fault_clr = 1'b0;
   logic [0:1] atb_req = 2'b00;
   real        vddana_1p8 = 1.8;
   real        vddana_0p8 = 0.8;
   real        vssana = 0.0;
   real        iclkdist_sense = 25.0e-6;
   real        icurrentsterring_sense = 500.0e-6;
   logic       pdb, bias_ready, fault;
   logic [0:1] atb_ena;
   logic [1:0] fault_code;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int mark     = 0;

   local_bias_ctrl dut (
      .clk(clk), .rstb(rstb), .en(en),
      .vddana_1p8(vddana_1p8), .vddana_0p8(vddana_0p8), .vssana(vssana),
      .iclkdist_sense(iclkdist_sense), .icurrentsterring_sense(icurrentsterring_sense),
      .atb_req(atb_req), .fault_clr(fault_clr),
      .pdb(pdb), .atb_ena(atb_ena), .bias_ready(bias_ready),
      .fault(fault), .fault_code(fault_code), .state(state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic set_nominal();
      vddana_1p8 = 1.8; vddana_0p8 = 0.8; vssana = 0.0;
      iclkdist_sense = 25.0e-6; icurrentsterring_sense = 500.0e-6;
   endtask

   task automatic do_reset();
      rstb = 1'b0; en = 1'b0; fault_clr = 1'b0; atb_req = 2'b00;
      set_nominal();
      step();
      rstb = 1'b1;
      mark = cyc;
   endtask

   // ---------------- reference model ----------------
   function automatic real nan_val();
      return $bitstoreal(64'h7FF8_0000_0000_0000);
   endfunction

   function automatic bit rail_ok(real v, real nom);
      if (v != v) return 1'b0;
      return (v >= nom * 0.95) && (v <= nom * 1.05);
   endfunction

   function automatic bit sup_ok_m(real a, real b, real c);
      return rail_ok(a, 1.8) && rail_ok(b, 0.8) && (c == c) && (c >= -0.05) && (c <= 0.05);
   endfunction

   function automatic bit cur_ok_m(real a, real b);
      return (a == a) && (b == b) &&
             (a >= 25.0e-6 * (1.0 - I_TOL)) && (a <= 25.0e-6 * (1.0 + I_TOL)) &&
             (b >= 500.0e-6 * (1.0 - I_TOL)) && (b <= 500.0e-6 * (1.0 + I_TOL));
   endfunction

   function automatic real rnd_rel(int span);
      return real'(int'($urandom_range(0, 2 * span)) - span) * 0.001;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_rails(input bit bad);
      vddana_1p8 = 1.8 * (1.0 + rnd_rel(40));
      vddana_0p8 = 0.8 * (1.0 + rnd_rel(40));
      case ($urandom_range(0, 3))
         0:       vssana = -0.05;
         1:       vssana = 0.05;
         default: vssana = rnd_rel(40);
      endcase
      if (bad) begin
         case ($urandom_range(0, 5))
            0:       vddana_1p8 = 1.60;
            1:       vddana_1p8 = 1.95;
            2:       vddana_0p8 = 0.70;
            3:       vssana = 0.06;
            4:       vssana = -0.06;
            default: vddana_0p8 = nan_val();
         endcase
      end
   endtask

   task automatic drive_currents(input bit bad);
      iclkdist_sense         = 25.0e-6 * (1.0 + rnd_rel(80));
      icurrentsterring_sense = 500.0e-6 * (1.0 + rnd_rel(80));
      if (bad) begin
         case ($urandom_range(0, 3))
            0:       icurrentsterring_sense = 400.0e-6;
            1:       icurrentsterring_sense = 560.0e-6;
            2:       iclkdist_sense = 20.0e-6;
            default: iclkdist_sense = nan_val();
         endcase
      end
   endtask

   // which: 0 = pdb, 1 = bias_ready, 2 = fault. rel = edges since mark, -1 if budget expired.
   task automatic wait_for(input int which, input int budget, output int rel);
      rel = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if ((which == 0 && pdb) || (which == 1 && bias_ready) || (which == 2 && fault)) begin
            rel = cyc - mark;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstb = 1'b0; en = 1'b1;
      step();
      n_checks++;
      if ({state, pdb, atb_ena, bias_ready, fault, fault_code} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_values: got %b exp %b", {state, pdb, atb_ena, bias_ready, fault, fault_code}, 10'd0);
      end
      en = 1'b0;
   endtask

   task automatic test_nominal();
      int rel;
      do_reset();
      en = 1'b1;
      wait_for(0, 200, rel);
      n_checks++;
      if (rel !== PDB_EDGE) begin n_fail++; $display("FAIL nominal_pdb_edge: got %0d exp %0d", rel, PDB_EDGE); end
      wait_for(1, 200, rel);
      n_checks++;
      if (rel !== FIRST_CHECK) begin n_fail++; $display("FAIL nominal_ready_edge: got %0d exp %0d", rel, FIRST_CHECK); end
      n_checks++;
      if ({state, fault, fault_code} !== {3'd4, 1'b0, 2'b00}) begin
         n_fail++; $display("FAIL nominal_ready_state: got %b exp %b", {state, fault, fault_code}, 6'b100000);
      end
   endtask

   task automatic test_debounce();
      for (int it = 0; it < 5; it++) begin
         int run, exp_edge, got;
         bit bad;
         do_reset();
         en = 1'b1;
         step();
         run = 0; exp_edge = -1; got = -1;
         for (int j = 0; j < 60; j++) begin
            if (it == 0) begin
               set_nominal();
               if (j == 5) vddana_0p8 = 0.70;
            end else begin
               bad = (j < 48) && ($urandom_range(0, 4) == 0);
               drive_rails(bad);
            end
            run = sup_ok_m(vddana_1p8, vddana_0p8, vssana) ? run + 1 : 0;
            if (run == SUP_DEBOUNCE && exp_edge < 0) exp_edge = j + 2;
            step();
            if (pdb && got < 0) got = cyc - mark;
            if (exp_edge >= 0 || got >= 0) break;
         end
         n_checks++;
         if (got !== exp_edge) begin n_fail++; $display("FAIL debounce_pdb_edge[%0d]: got %0d exp %0d", it, got, exp_edge); end
         n_checks++;
         if ({state, fault} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL debounce_state[%0d]: got %0d exp 2", it, state); end
      end
   endtask

   task automatic test_verify();
      int m_list[5];
      m_list = '{0, 0, VERIFY_TIMEOUT - 1, VERIFY_TIMEOUT, VERIFY_TIMEOUT + 5};
      m_list[1] = int'($urandom_range(1, VERIFY_TIMEOUT - 2));
      foreach (m_list[k]) begin
         int m, got_rdy, got_flt, exp_rdy, exp_flt;
         m = m_list[k];
         do_reset();
         en = 1'b1;
         got_rdy = -1; got_flt = -1;
         exp_rdy = -1; exp_flt = -1;
         for (int e = 1; e <= FIRST_CHECK + VERIFY_TIMEOUT + 8; e++) begin
            drive_currents(e < FIRST_CHECK + m);
            if (cur_ok_m(iclkdist_sense, icurrentsterring_sense) && e >= FIRST_CHECK && exp_rdy < 0 && exp_flt < 0)
               exp_rdy = e;
            if (e == FIRST_CHECK + VERIFY_TIMEOUT - 1 && exp_rdy < 0) exp_flt = e;
            step();
            if (bias_ready && got_rdy < 0) got_rdy = cyc - mark;
            if (fault && got_flt < 0) got_flt = cyc - mark;
            if (got_rdy >= 0 || got_flt >= 0) break;
         end
         n_checks++;
         if (got_rdy !== exp_rdy) begin n_fail++; $display("FAIL verify_ready_edge[m=%0d]: got %0d exp %0d", m, got_rdy, exp_rdy); end
         n_checks++;
         if (got_flt !== exp_flt) begin n_fail++; $display("FAIL verify_fault_edge[m=%0d]: got %0d exp %0d", m, got_flt, exp_flt); end
         n_checks++;
         if (fault_code !== ((exp_flt >= 0) ? 2'b10 : 2'b00)) begin
            n_fail++; $display("FAIL verify_code[m=%0d]: got %b", m, fault_code);
         end
      end
   endtask

   task automatic test_fault_clear();
      int rel;
      do_reset();
      icurrentsterring_sense = 400.0e-6;
      en = 1'b1;
      wait_for(2, 300, rel);
      n_checks++;
      if (rel !== FIRST_CHECK + VERIFY_TIMEOUT - 1) begin
         n_fail++; $display("FAIL tol_fault_edge: got %0d exp %0d", rel, FIRST_CHECK + VERIFY_TIMEOUT - 1);
      end
      n_checks++;
      if ({fault_code, pdb, bias_ready} !== 4'b1000) begin
         n_fail++; $display("FAIL tol_fault_outputs: got %b exp 1000", {fault_code, pdb, bias_ready});
      end
      fault_clr = 1'b1;
      for (int i = 0; i < 3; i++) step();
      n_checks++;
      if ({state, fault, fault_code} !== {3'd5, 1'b1, 2'b10}) begin
         n_fail++; $display("FAIL clr_with_en_ignored: got %b exp 101110", {state, fault, fault_code});
      end
      en = 1'b0;
      step();
      n_checks++;
      if ({state, fault, fault_code, pdb} !== 7'd0) begin
         n_fail++; $display("FAIL clr_to_off: got %b exp 0000000", {state, fault, fault_code, pdb});
      end
      fault_clr = 1'b0;
   endtask

   task automatic test_ready_monitor();
      for (int it = 0; it < 4; it++) begin
         int rel, exp_k, got_k;
         bit bad, prev_bad;
         do_reset();
         en = 1'b1;
         wait_for(1, 200, rel);
         n_checks++;
         if (rel !== FIRST_CHECK) begin n_fail++; $display("FAIL monitor_ready[%0d]: got %0d exp %0d", it, rel, FIRST_CHECK); end
         exp_k = -1; got_k = -1; prev_bad = 1'b0;
         for (int k = 0; k < 24; k++) begin
            bad = (k == 0) ? 1'b1 : (k == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
            drive_currents(bad);
            bad = !cur_ok_m(iclkdist_sense, icurrentsterring_sense);
            if (bad && prev_bad && exp_k < 0) exp_k = k;
            prev_bad = bad;
            step();
            if (fault && got_k < 0) got_k = k;
            if (exp_k >= 0 || got_k >= 0) break;
         end
         n_checks++;
         if (got_k !== exp_k) begin n_fail++; $display("FAIL monitor_fault_sample[%0d]: got %0d exp %0d", it, got_k, exp_k); end
         n_checks++;
         if (exp_k >= 0 && {bias_ready, fault_code} !== 3'b010) begin
            n_fail++; $display("FAIL monitor_fault_code[%0d]: got %b exp 010", it, {bias_ready, fault_code});
         end else if (exp_k < 0 && {bias_ready, state} !== 4'b1100) begin
            n_fail++; $display("FAIL monitor_still_ready[%0d]: got %b exp 1100", it, {bias_ready, state});
         end
      end
   endtask

   task automatic test_supply_loss();
      for (int it = 0; it < 3; it++) begin
         int rel;
         // rail loss in READY
         do_reset();
         en = 1'b1;
         wait_for(1, 200, rel);
         atb_req = 2'b11;
         step();
         if (it == 0) vddana_1p8 = 1.60; else drive_rails(1'b1);
         step();
         n_checks++;
         if ({state, fault_code, bias_ready, atb_ena, pdb, fault} !== {3'd5, 2'b01, 1'b0, 2'b00, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL ready_rail_loss[%0d]: got %b exp 101010001", it, {state, fault_code, bias_ready, atb_ena, pdb, fault});
         end
         // rail loss in SETTLE
         do_reset();
         en = 1'b1;
         wait_for(0, 200, rel);
         for (int i = 0; i < int'($urandom_range(0, SETTLE_CYCLES - 4)); i++) step();
         drive_rails(1'b1);
         step();
         n_checks++;
         if ({state, fault_code, pdb} !== {3'd5, 2'b11, 1'b0}) begin
            n_fail++; $display("FAIL settle_rail_loss[%0d]: got %b exp 101110", it, {state, fault_code, pdb});
         end
         // rail loss in VERIFY (currents held bad so VERIFY persists)
         do_reset();
         icurrentsterring_sense = 400.0e-6;
         en = 1'b1;
         for (int i = 0; i < FIRST_CHECK + int'($urandom_range(0, VERIFY_TIMEOUT - 3)); i++) step();
         drive_rails(1'b1);
         icurrentsterring_sense = 400.0e-6;
         step();
         n_checks++;
         if ({state, fault_code} !== {3'd5, 2'b01}) begin
            n_fail++; $display("FAIL verify_rail_loss[%0d]: got %b exp 10101", it, {state, fault_code});
         end
      end
   endtask

   task automatic test_atb();
      logic [1:0] exp_q[$];
      logic [1:0] req, exp_v;
      int rel;
      do_reset();
      en = 1'b1;
      wait_for(1, 200, rel);
      for (int i = 0; i < 12; i++) begin
         req = (i == 0) ? 2'b11 : (i == 1) ? 2'b01 : 2'($urandom_range(0, 3));
         atb_req = req;
         exp_q.push_back(req);
         step();
         exp_v = exp_q.pop_front();
         n_checks++;
         if (atb_ena !== exp_v) begin n_fail++; $display("FAIL atb_follow[%0d]: got %b exp %b", i, atb_ena, exp_v); end
      end
      atb_req = 2'b11;
      en = 1'b0;
      step();
      n_checks++;
      if ({state, atb_ena, pdb, bias_ready, fault} !== 8'd0) begin
         n_fail++; $display("FAIL atb_en_drop: got %b exp 00000000", {state, atb_ena, pdb, bias_ready, fault});
      end
   endtask

   task automatic test_en_drop();
      for (int it = 0; it < 5; it++) begin
         int r;
         do_reset();
         if ($urandom_range(0, 1) == 1) icurrentsterring_sense = 400.0e-6;
         r = int'($urandom_range(1, FIRST_CHECK + VERIFY_TIMEOUT - 8));
         en = 1'b1;
         for (int i = 0; i < r; i++) step();
         en = 1'b0;
         step();
         n_checks++;
         if ({state, pdb, bias_ready, fault, fault_code} !== 8'd0) begin
            n_fail++; $display("FAIL en_drop[r=%0d]: got %b exp 00000000", r, {state, pdb, bias_ready, fault, fault_code});
         end
      end
   endtask

   task automatic test_reset_mid_settle();
      int rel;
      do_reset();
      en = 1'b1;
      wait_for(0, 200, rel);
      for (int i = 0; i < int'($urandom_range(1, SETTLE_CYCLES - 4)); i++) step();
      rstb = 1'b0;
      step();
      n_checks++;
      if ({state, pdb, atb_ena, bias_ready, fault, fault_code} !== 10'd0) begin
         n_fail++; $display("FAIL mid_settle_reset: got %b exp %b", {state, pdb, atb_ena, bias_ready, fault, fault_code}, 10'd0);
      end
      rstb = 1'b1;
      mark = cyc;
      wait_for(0, 200, rel);
      n_checks++;
      if (rel !== PDB_EDGE) begin n_fail++; $display("FAIL restart_pdb_edge: got %0d exp %0d", rel, PDB_EDGE); end
      wait_for(1, 200, rel);
      n_checks++;
      if (rel !== FIRST_CHECK) begin n_fail++; $display("FAIL restart_ready_edge: got %0d exp %0d", rel, FIRST_CHECK); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_nominal();
      test_debounce();
      test_verify();
      test_fault_clear();
      test_ready_monitor();
      test_supply_loss();
      test_atb();
      test_en_drop();
      test_reset_mid_settle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
